// File: rtl/pwm_channel_fader_if.sv
// rtl/pwm_channel_fader_if.sv - configuration write port and PWM outputs of pwm_channel_fader
interface pwm_channel_fader_if #(
  parameter int NUM_CH        = 3,
  parameter int COUNTER_WIDTH = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                     cfg_wr;
  logic [CH_W-1:0]          cfg_ch;
  logic [1:0]               cfg_mode;
  logic [COUNTER_WIDTH-1:0] cfg_duty;
  logic [NUM_CH-1:0]        pwm_out;
  logic                     period_start;

  modport master (
    output cfg_wr, cfg_ch, cfg_mode, cfg_duty,
    input  pwm_out, period_start
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_mode, cfg_duty,
    output pwm_out, period_start
  );
endinterface

// File: rtl/pwm_channel_fader.sv
// rtl/pwm_channel_fader.sv - multi-channel PWM driver with off/static/breathe modes
module pwm_channel_fader #(
  parameter int NUM_CH        = 3,
  parameter int COUNTER_WIDTH = 8,
  parameter int MAX_COUNT     = 255,
  parameter int FADE_DIV      = 4,
  parameter int FADE_STEP     = 1,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input logic               clk_in,
  input logic               rst_n_in,
  pwm_channel_fader_if.slave cfg
);
  localparam int CW   = COUNTER_WIDTH;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST     = DW'(FADE_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST     = CW'(MAX_COUNT);
  localparam logic [CW:0]   STEP_EXT     = (CW + 1)'(FADE_STEP);
  localparam logic [CW-1:0] STEP_LO      = CW'(FADE_STEP);
  localparam logic [1:0]    MODE_STATIC  = 2'd1;
  localparam logic [1:0]    MODE_BREATHE = 2'd2;

  logic [CW-1:0] cnt;
  logic [DW-1:0] divCnt;
  logic          periodStart;
  logic [NUM_CH-1:0] pwmReg;

  logic [1:0]    modeS [NUM_CH];
  logic [CW-1:0] dutyS [NUM_CH];
  logic [1:0]    modeW [NUM_CH];
  logic [CW-1:0] dutyW [NUM_CH];
  logic [CW-1:0] fade  [NUM_CH];
  logic [NUM_CH-1:0] dir;

  logic [1:0]    modeNext  [NUM_CH];
  logic [CW-1:0] dutyNext  [NUM_CH];
  logic [CW-1:0] fadeNext  [NUM_CH];
  logic [CW-1:0] lvl       [NUM_CH];
  logic [CW-1:0] clampFade [NUM_CH];
  logic [CW:0]   upSum     [NUM_CH];
  logic [NUM_CH-1:0] clampDir;
  logic [NUM_CH-1:0] dirNext;
  logic [NUM_CH-1:0] wrHit;
  logic [NUM_CH-1:0] chOn;

  logic cntEnd;
  logic fadeStep;

  assign cntEnd   = (cnt == CNT_LAST);
  assign fadeStep = cntEnd && (divCnt == DIV_LAST);

  assign cfg.pwm_out      = pwmReg;
  assign cfg.period_start = periodStart;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // Out-of-range channel numbers simply match no channel.
      wrHit[i]    = cfg.cfg_wr && (cfg.cfg_ch == CH_W'(i));
      // A write landing on the terminal count bypasses the shadow so it is not lost.
      modeNext[i] = wrHit[i] ? cfg.cfg_mode : modeS[i];
      dutyNext[i] = wrHit[i] ? cfg.cfg_duty : dutyS[i];

      case (modeW[i])
        MODE_STATIC:  lvl[i] = dutyW[i];
        MODE_BREATHE: lvl[i] = fade[i];
        default:      lvl[i] = '0;
      endcase
      chOn[i] = (lvl[i] > cnt);

      clampFade[i] = fade[i];
      clampDir[i]  = dir[i];
      if (fade[i] > dutyNext[i]) begin
        clampFade[i] = dutyNext[i];
        clampDir[i]  = 1'b0;
      end
      upSum[i]    = {1'b0, clampFade[i]} + STEP_EXT;
      fadeNext[i] = clampFade[i];
      dirNext[i]  = clampDir[i];
      if (fadeStep) begin
        if (clampDir[i]) begin
          if (upSum[i] >= {1'b0, dutyNext[i]}) begin
            fadeNext[i] = dutyNext[i];
            dirNext[i]  = 1'b0;
          end else begin
            fadeNext[i] = upSum[i][CW-1:0];
          end
        end else begin
          if ({1'b0, clampFade[i]} <= STEP_EXT) begin
            fadeNext[i] = '0;
            dirNext[i]  = 1'b1;
          end else begin
            fadeNext[i] = clampFade[i] - STEP_LO;
          end
        end
      end

      // Entering breathe starts a fresh ramp; leaving it parks the fader at zero.
      if (modeNext[i] != MODE_BREATHE || modeW[i] != MODE_BREATHE) begin
        fadeNext[i] = '0;
        dirNext[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt         <= '0;
      divCnt      <= '0;
      periodStart <= 1'b0;
      pwmReg      <= {NUM_CH{ACTIVE_LOW}};
      dir         <= '1;
      for (int i = 0; i < NUM_CH; i++) begin
        modeS[i] <= '0;
        dutyS[i] <= '0;
        modeW[i] <= '0;
        dutyW[i] <= '0;
        fade[i]  <= '0;
      end
    end else begin
      cnt         <= cntEnd ? '0 : cnt + 1'b1;
      periodStart <= (cnt == '0);
      pwmReg      <= ACTIVE_LOW ? ~chOn : chOn;
      if (cntEnd) begin
        divCnt <= (divCnt == DIV_LAST) ? '0 : divCnt + 1'b1;
        dir    <= dirNext;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (wrHit[i]) begin
          modeS[i] <= cfg.cfg_mode;
          dutyS[i] <= cfg.cfg_duty;
        end
        if (cntEnd) begin
          modeW[i] <= modeNext[i];
          dutyW[i] <= dutyNext[i];
          fade[i]  <= fadeNext[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_channel_fader.sv
// tb/tb_pwm_channel_fader.sv - directed self-checking bench for pwm_channel_fader
module tb_pwm_channel_fader;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pwm_channel_fader_if #(.NUM_CH(3), .COUNTER_WIDTH(8)) bus ();

  pwm_channel_fader #(
    .NUM_CH(3), .COUNTER_WIDTH(8), .MAX_COUNT(255),
    .FADE_DIV(2), .FADE_STEP(1), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .cfg     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic waitStart();
    int guard;
    guard = 0;
    while (bus.period_start !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (bus.period_start !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL period_start_timeout: period_start=%b required=1 within 300 cycles", bus.period_start);
    end
  endtask

  task automatic cfgWrite(input int ch, input int mode, input int duty);
    bus.cfg_wr   = 1'b1;
    bus.cfg_ch   = 2'(ch);
    bus.cfg_mode = 2'(mode);
    bus.cfg_duty = 8'(duty);
    @(negedge clk);
    bus.cfg_wr   = 1'b0;
  endtask

  task automatic measurePeriod(output int on0, output int on1, output int on2, output int starts);
    waitStart();
    on0 = 0; on1 = 0; on2 = 0; starts = 0;
    for (int k = 0; k < 256; k++) begin
      on0    += int'(!bus.pwm_out[0]);
      on1    += int'(!bus.pwm_out[1]);
      on2    += int'(!bus.pwm_out[2]);
      starts += int'(bus.period_start);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int starts, darkBad;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.pwm_out !== 3'b111) begin bad++; $display("FAIL reset_pwm: got=%b want=111", bus.pwm_out); end
    total++;
    if (bus.period_start !== 1'b0) begin bad++; $display("FAIL reset_period_start: got=%b want=0", bus.period_start); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.period_start !== 1'b1) begin bad++; $display("FAIL first_start: got=%b want=1", bus.period_start); end
    starts = 0; darkBad = 0;
    for (int i = 1; i <= 1024; i++) begin
      @(negedge clk);
      starts  += int'(bus.period_start === 1'b1);
      darkBad += int'(bus.pwm_out !== 3'b111);
    end
    total++;
    if (starts != 4) begin bad++; $display("FAIL start_count: got=%0d want=4", starts); end
    total++;
    if (darkBad != 0) begin bad++; $display("FAIL idle_dark: lit_cycles=%0d want=0", darkBad); end
    total++;
    if (bus.period_start !== 1'b1) begin bad++; $display("FAIL start_spacing: got=%b want=1 at cycle 1024", bus.period_start); end
  endtask

  task automatic test_static_sweep();
    int duties[4] = '{0, 1, 128, 255};
    int on0, on1, on2, st;
    for (int d = 0; d < 4; d++) begin
      waitStart();
      cfgWrite(0, 1, duties[d]);
      measurePeriod(on0, on1, on2, st);
      total++;
      if (on0 != duties[d]) begin bad++; $display("FAIL sweep_ch0 duty=%0d: on=%0d want=%0d", duties[d], on0, duties[d]); end
      total++;
      if (on1 != 0) begin bad++; $display("FAIL sweep_ch1 duty=%0d: on=%0d want=0", duties[d], on1); end
      total++;
      if (on2 != 0) begin bad++; $display("FAIL sweep_ch2 duty=%0d: on=%0d want=0", duties[d], on2); end
    end
  endtask

  task automatic test_double_write();
    int cur0, cur1, on0, on1, on2, st;
    waitStart();
    cur0 = 0; cur1 = 0;
    for (int k = 0; k < 256; k++) begin
      cur0 += int'(!bus.pwm_out[0]);
      cur1 += int'(!bus.pwm_out[1]);
      bus.cfg_wr = 1'b0;
      if (k == 9 || k == 254) begin
        bus.cfg_wr   = 1'b1;
        bus.cfg_ch   = 2'd1;
        bus.cfg_mode = 2'd1;
        bus.cfg_duty = (k == 9) ? 8'd64 : 8'd200;
      end
      @(negedge clk);
    end
    bus.cfg_wr = 1'b0;
    total++;
    if (cur1 != 0) begin bad++; $display("FAIL overwrite_current_ch1: on=%0d want=0", cur1); end
    total++;
    if (cur0 != 255) begin bad++; $display("FAIL overwrite_current_ch0: on=%0d want=255", cur0); end
    for (int p = 0; p < 2; p++) begin
      measurePeriod(on0, on1, on2, st);
      total++;
      if (on1 != 200) begin bad++; $display("FAIL overwrite_next_ch1 p=%0d: on=%0d want=200", p, on1); end
    end
  endtask

  task automatic test_bad_channel();
    int on0, on1, on2, st;
    waitStart();
    repeat (254) @(negedge clk);
    cfgWrite(3, 1, 10);
    measurePeriod(on0, on1, on2, st);
    total++;
    if (on0 != 255) begin bad++; $display("FAIL badch_ch0: on=%0d want=255", on0); end
    total++;
    if (on1 != 200) begin bad++; $display("FAIL badch_ch1: on=%0d want=200", on1); end
    total++;
    if (on2 != 0) begin bad++; $display("FAIL badch_ch2: on=%0d want=0", on2); end
  endtask

  task automatic test_breathe();
    int expSeq[20] = '{0,0,1,1,2,2,3,3,4,4,3,3,2,2,1,1,0,0,1,1};
    int on0, on1, on2, st, others;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    waitStart();
    @(negedge clk);
    waitStart();
    cfgWrite(2, 2, 4);
    others = 0;
    for (int p = 0; p < 20; p++) begin
      measurePeriod(on0, on1, on2, st);
      others += on0 + on1;
      total++;
      if (on2 != expSeq[p]) begin bad++; $display("FAIL breathe_p%0d: on=%0d want=%0d", p, on2, expSeq[p]); end
    end
    total++;
    if (others != 0) begin bad++; $display("FAIL breathe_others: on=%0d want=0", others); end
  endtask

  task automatic test_reset_mid();
    int on0, on1, on2, st;
    waitStart();
    cfgWrite(0, 1, 200);
    waitStart();
    repeat (50) @(negedge clk);
    total++;
    if (bus.pwm_out !== 3'b110) begin bad++; $display("FAIL pre_reset_lit: got=%b want=110", bus.pwm_out); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.pwm_out !== 3'b111) begin bad++; $display("FAIL async_dark: got=%b want=111", bus.pwm_out); end
    total++;
    if (bus.period_start !== 1'b0) begin bad++; $display("FAIL async_start: got=%b want=0", bus.period_start); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.period_start !== 1'b1) begin bad++; $display("FAIL restart_start: got=%b want=1", bus.period_start); end
    measurePeriod(on0, on1, on2, st);
    total++;
    if ((on0 + on1 + on2) != 0) begin bad++; $display("FAIL restart_off: on=%0d/%0d/%0d want=0/0/0", on0, on1, on2); end
    total++;
    if (st != 1) begin bad++; $display("FAIL restart_starts: got=%0d want=1", st); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.cfg_wr   = 1'b0;
    bus.cfg_ch   = '0;
    bus.cfg_mode = '0;
    bus.cfg_duty = '0;
    test_reset();
    test_static_sweep();
    test_double_write();
    test_bad_channel();
    test_breathe();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
